result_collect_4to1: RTL and testbench

Sequential result collector for the multicycle arithmetic datapath. It is the return path of the 4-way operand demux: it accepts an opcode at operation start, waits for the done pulse of the arithmetic unit that opcode selected, and captures that unit's result. It then presents the result downstream on a valid/ready handshake. It sits between the four arithmetic units (00 add, 01 sub, 10 mul, 11 div) and the result register or display stage.

---
 rtl/result_collect_4to1.sv | 153 +++++++++++++++
 tb/tb_result_collect_4to1.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_collect_4to1.sv
// result_collect_4to1: return path of the 4-way arithmetic demux.
// An accepted start records the selected unit. The block then waits for that
// unit's done pulse, captures its result, and presents it on a valid/ready
// handshake. Only one operation is in flight at a time.
// Optional feature: define RESCOL_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles. The abort delivers out_data_o=0 with out_err_o=1.
module result_collect_4to1 #(
  parameter int unsigned RES_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       opcode_i,
  output logic             start_ready_o,
  input  logic [3:0]       unit_done_i,
  input  logic [RES_W-1:0] unit_res0_i,
  input  logic [RES_W-1:0] unit_res1_i,
  input  logic [RES_W-1:0] unit_res2_i,
  input  logic [RES_W-1:0] unit_res3_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RES_W-1:0] out_data_o,
  output logic [1:0]       out_op_o,
  output logic             out_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_data_q, out_data_d;
  logic [1:0]       out_op_q, out_op_d;
  logic [RES_W-1:0] sel_res;
  logic             sel_done;

`ifdef RESCOL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_err_q, out_err_d;
`endif

  // Route the selected unit's result and done bit.
  always_comb begin
    sel_res = unit_res0_i;
    case (sel_q)
      2'd0:    sel_res = unit_res0_i;
      2'd1:    sel_res = unit_res1_i;
      2'd2:    sel_res = unit_res2_i;
      default: sel_res = unit_res3_i;
    endcase
    sel_done = unit_done_i[sel_q];
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_op_d    = out_op_q;
`ifdef RESCOL_TIMEOUT_EN
    cnt_d       = cnt_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A done pulse in the same cycle as start belongs to no operation.
        if (start_i) begin
          sel_d   = opcode_i;
          state_d = S_WAIT;
`ifdef RESCOL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        // A real result beats a timeout that expires in the same cycle.
        if (sel_done) begin
          out_data_d  = sel_res;
          out_op_d    = sel_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
`ifdef RESCOL_TIMEOUT_EN
          out_err_d   = 1'b0;
`endif
        end
`ifdef RESCOL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          out_data_d  = '0;
          out_op_d    = sel_q;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= 2'd0;
`ifdef RESCOL_TIMEOUT_EN
      cnt_q       <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_op_q    <= out_op_d;
`ifdef RESCOL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign start_ready_o = (state_q == S_IDLE);
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_op_o      = out_op_q;
`ifdef RESCOL_TIMEOUT_EN
  assign out_err_o     = out_err_q;
`else
  assign out_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_result_collect_4to1.sv
// Directed bench for result_collect_4to1 with a transaction-level reference
// model. Define RESCOL_TIMEOUT_EN to also exercise the timeout path.
module tb_result_collect_4to1;

  localparam int unsigned RES_W = 8;
  localparam int unsigned TMO   = 15;
`ifdef RESCOL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       opcode = 2'd0;
  logic [3:0]       unit_done = 4'd0;
  logic [RES_W-1:0] res [4];
  logic             out_ready = 1'b0;
  logic             start_ready;
  logic             out_valid;
  logic [RES_W-1:0] out_data;
  logic [1:0]       out_op;
  logic             out_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  result_collect_4to1 #(.RES_W(RES_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opcode),
    .start_ready_o(start_ready), .unit_done_i(unit_done),
    .unit_res0_i(res[0]), .unit_res1_i(res[1]),
    .unit_res2_i(res[2]), .unit_res3_i(res[3]),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_op_o(out_op), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  // Reference model: one operation in flight (m_busy) or one result on offer (m_have).
  bit         m_busy, m_have, m_err;
  logic [1:0] m_sel, m_op;
  logic [7:0] m_data;
  int         m_waited;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_have = 0; m_err = 0; m_sel = 0; m_op = 0; m_data = 0; m_waited = 0;
    end else if (m_have) begin
      if (out_ready) m_have = 0;
    end else if (m_busy) begin
      if (unit_done[m_sel]) begin
        m_data = res[m_sel]; m_op = m_sel; m_err = 0; m_have = 1; m_busy = 0;
      end else if (TMO_EN && (m_waited + 1 >= int'(TMO))) begin
        m_data = 0; m_op = m_sel; m_err = 1; m_have = 1; m_busy = 0;
      end else begin
        m_waited++;
      end
    end else if (start) begin
      m_busy = 1; m_sel = opcode; m_waited = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (start_ready !== !(m_busy || m_have) || out_valid !== m_have ||
          out_data !== m_data || out_op !== m_op || out_err !== m_err) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t: got rdy=%b v=%b d=%h op=%0d err=%b want rdy=%b v=%b d=%h op=%0d err=%b",
                 $time, start_ready, out_valid, out_data, out_op, out_err,
                 !(m_busy || m_have), m_have, m_data, m_op, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start for the given opcode (one edge).
  task automatic issue(input logic [1:0] op);
    start = 1'b1; opcode = op;
    tick();
    start = 1'b0;
  endtask

  // Pulse a set of done bits with a result on every unit for one edge.
  task automatic pulse(input logic [3:0] done, input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] r2, input logic [7:0] r3);
    unit_done = done; res[0] = r0; res[1] = r1; res[2] = r2; res[3] = r3;
    tick();
    unit_done = 4'd0;
  endtask

  initial begin
    res[0] = 0; res[1] = 0; res[2] = 0; res[3] = 0;
    tick();
    cmp_en = 1'b1;
    chk("rst_ready", 32'(start_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_op", 32'(out_op), 0);
    chk("rst_err", 32'(out_err), 0);
    rst = 1'b0;

    // Basic mul: done five cycles after start, immediate handoff.
    out_ready = 1'b1;
    issue(2'd2);
    chk("mul_wait_ready", 32'(start_ready), 0);
    repeat (5) tick();
    chk("mul_no_valid_yet", 32'(out_valid), 0);
    pulse(4'b0100, 8'h11, 8'h22, 8'h2D, 8'h44);
    chk("mul_valid", 32'(out_valid), 1);
    chk("mul_data", 32'(out_data), 32'h2D);
    chk("mul_op", 32'(out_op), 2);
    chk("mul_err", 32'(out_err), 0);
    tick();
    chk("mul_handoff_valid", 32'(out_valid), 0);
    chk("mul_handoff_ready", 32'(start_ready), 1);
    chk("mul_data_kept", 32'(out_data), 32'h2D);

    // Reset mid-WAIT, then a late done must be ignored.
    issue(2'd2);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_valid", 32'(out_valid), 0);
    chk("rstw_ready", 32'(start_ready), 1);
    chk("rstw_data", 32'(out_data), 0);
    tick();
    rst = 1'b0;
    pulse(4'b0100, 8'h00, 8'h00, 8'h77, 8'h00);
    chk("rstw_late_done", 32'(out_valid), 0);
    tick();

    // Wrong-unit filtering.
    issue(2'd1);
    pulse(4'b0001, 8'hAA, 8'h00, 8'h00, 8'h00);
    chk("wrong_unit_ignored", 32'(out_valid), 0);
    pulse(4'b0010, 8'hAA, 8'h03, 8'h00, 8'h00);
    chk("sub_data", 32'(out_data), 32'h03);
    chk("sub_op", 32'(out_op), 1);
    tick();

    // Backpressure with start held high, then handoff with start still high.
    out_ready = 1'b0;
    issue(2'd3);
    pulse(4'b1000, 8'h00, 8'h00, 8'h00, 8'h5C);
    start = 1'b1; opcode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h5C);
      chk("bp_ready", 32'(start_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_handoff_valid", 32'(out_valid), 0);
    chk("bp_no_overlap", 32'(start_ready), 1);
    start = 1'b0;
    tick();

    // Done in the same cycle as start is ignored.
    start = 1'b1; opcode = 2'd0;
    pulse(4'b0001, 8'h11, 8'h00, 8'h00, 8'h00);
    start = 1'b0;
    chk("dws_ignored", 32'(out_valid), 0);
    chk("dws_in_wait", 32'(start_ready), 0);
    tick();
    pulse(4'b0001, 8'h09, 8'h00, 8'h00, 8'h00);
    chk("dws_data", 32'(out_data), 32'h09);
    chk("dws_op", 32'(out_op), 0);
    tick();

    // Simultaneous done bits: only the selected one counts.
    issue(2'd2);
    pulse(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    chk("multi_data", 32'(out_data), 32'hA2);
    tick();

    // Back-to-back operations at the minimum three-cycle interval.
    for (int k = 0; k < 3; k++) begin
      issue(2'(k));
      pulse(4'b1111, 8'h30, 8'h31, 8'h32, 8'h33);
      chk("b2b_data", 32'(out_data), 32'h30 + 32'(k));
      tick();
      chk("b2b_ready", 32'(start_ready), 1);
    end

`ifdef RESCOL_TIMEOUT_EN
    // Timeout with no done, then done arriving on the limit cycle.
    issue(2'd3);
    repeat (14) tick();
    chk("tmo_not_yet", 32'(out_valid), 0);
    out_ready = 1'b0;
    tick();
    chk("tmo_valid", 32'(out_valid), 1);
    chk("tmo_err", 32'(out_err), 1);
    chk("tmo_data", 32'(out_data), 0);
    chk("tmo_op", 32'(out_op), 3);
    out_ready = 1'b1;
    tick();
    issue(2'd3);
    repeat (14) tick();
    pulse(4'b1000, 8'h00, 8'h00, 8'h00, 8'hE7);
    chk("tmo_tie_err", 32'(out_err), 0);
    chk("tmo_tie_data", 32'(out_data), 32'hE7);
    tick();
`else
    // Without timeout a long WAIT simply persists.
    issue(2'd1);
    repeat (30) tick();
    chk("long_wait_valid", 32'(out_valid), 0);
    chk("long_wait_ready", 32'(start_ready), 0);
    pulse(4'b0010, 8'h00, 8'h6B, 8'h00, 8'h00);
    chk("long_wait_data", 32'(out_data), 32'h6B);
    chk("long_wait_err", 32'(out_err), 0);
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
